// File: rtl/filt_pkg.sv
// Types and widths shared by the filter read-address counter and result writer.
package filt_pkg;

    localparam int FILT_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } filt_state_e;

endpackage

// File: rtl/filt_result_writer_if.sv
// Result stream in from the accelerator plus the write port out to result memory.
interface filt_result_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              pause;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    // slave: the writer itself; master: accelerator and memory side
    modport slave (
        input  in_data, in_valid, pause,
        output in_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output in_data, in_valid, pause,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/filt_skid_fifo.sv
// Two-entry FIFO between the accelerator handshake and the memory issue slot.
module filt_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
endmodule

// File: rtl/filt_result_writer.sv
// Buffers accelerator results and writes them to sequential addresses, one write every other cycle.
module filt_result_writer
    import filt_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [FILT_CNT_W-1:0] filesize,
    filt_result_writer_if.slave   bus,
    output logic [FILT_CNT_W-1:0] count,
    output logic                  done
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HOLD = ST_HOLD;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]            r_state;
    logic [FILT_CNT_W-1:0] r_size;
    logic [FILT_CNT_W-1:0] r_acc;
    logic [FILT_CNT_W-1:0] r_count;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_data;
    logic                  r_done;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_clear;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_W-1:0]     w_head;
    logic [ADDR_W-1:0]     w_next_addr;

    assign w_clear     = !enable;
    assign w_in_ready  = (r_state == S_RUN || r_state == S_HOLD) && !w_full && (r_acc < r_size);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = enable && (r_state == S_RUN) && !w_empty && !bus.pause;
    assign w_next_addr = BASE_ADDR + ADDR_W'(r_count);

    filt_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.in_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_size     <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_done     <= 1'b0;
        end else if (!enable) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_push) r_acc <= r_acc + FILT_CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_size <= filesize;
                    if (filesize == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_next_addr;
                        r_mem_data <= w_head;
                        r_count    <= r_count + FILT_CNT_W'(1);
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_count == r_size) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE:  r_done  <= 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign count        = r_count;
    assign done         = r_done;
endmodule

// File: tb/tb_filt_result_writer.sv
// Directed bench for filt_result_writer: main 32-bit instance plus a 4-bit address wrap instance.
module tb_filt_result_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] filesize;
    logic [31:0] count;
    logic        done;
    logic        enable2;
    logic [31:0] filesize2;
    logic [31:0] count2;
    logic        done2;

    filt_result_writer_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    filt_result_writer_if #(.DATA_W(32), .ADDR_W(4))  bus2 ();

    filt_result_writer #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .filesize(filesize),
        .bus(bus.slave), .count(count), .done(done)
    );

    filt_result_writer #(.DATA_W(32), .ADDR_W(4), .BASE_ADDR(4'd14)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable2), .filesize(filesize2),
        .bus(bus2.slave), .count(count2), .done(done2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cnt, idx, n_offer, consec;
    bit prev_we, ready_seen;
    logic [31:0] data_base;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    logic [3:0]  wa2[$];

    // One clock: observe at negedge, then drive inputs #1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
            hs_cnt++;
            idx++;
        end
        if (bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_data);
            wc.push_back(cyc);
            if (prev_we) consec++;
        end
        prev_we = bus.mem_we;
        if (bus.in_ready) ready_seen = 1'b1;
        if (bus2.mem_we) wa2.push_back(bus2.mem_addr);
        cyc++;
        @(posedge clk);
        #1;
        bus.in_valid = (idx < n_offer);
        bus.in_data  = data_base + 32'(idx);
    endtask

    task automatic start_run(input logic [31:0] size, input int n, input logic [31:0] base);
        enable       = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        wa.delete(); wd.delete(); wc.delete();
        hs_cnt = 0; idx = 0; n_offer = n; data_base = base;
        prev_we = 1'b0; consec = 0; ready_seen = 1'b0;
        filesize     = size;
        enable       = 1'b1;
        bus.in_valid = (n > 0);
        bus.in_data  = base;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done; k++) tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
        filesize = '0; filesize2 = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.pause = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.pause = 1'b0;
        n_offer = 0; idx = 0; data_base = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_data !== 32'd0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", bus.mem_data); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_run(32'd4, 4, 32'hA0);
        wait_done(60);
        checks++; if (wa.size() !== 4) begin errors++; $display("FAIL basic_writes: got %0d want 4", wa.size()); end
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[i] !== 32'(i) || wd[i] !== 32'hA0 + 32'(i)) begin
                    errors++;
                    $display("FAIL basic_word%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, 32'hA0 + 32'(i));
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (wc[i] - wc[i-1] !== 2) begin errors++; $display("FAIL basic_spacing%0d: got %0d want 2", i, wc[i] - wc[i-1]); end
            end
        end
        checks++; if (count !== 32'd4) begin errors++; $display("FAIL basic_count: got %0d want 4", count); end
        checks++; if (consec !== 0) begin errors++; $display("FAIL basic_consec_we: got %0d want 0", consec); end
    endtask

    task automatic test_pause();
        start_run(32'd3, 3, 32'hB0);
        bus.pause = 1'b1;
        for (int k = 0; k < 20 && hs_cnt < 1; k++) tick();
        repeat (5) tick();
        checks++; if (wa.size() !== 0) begin errors++; $display("FAIL pause_no_write: got %0d writes want 0", wa.size()); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL pause_ready_full: got %0b want 0", bus.in_ready); end
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL pause_buffered: got %0d want 2", hs_cnt); end
        bus.pause = 1'b0;
        wait_done(60);
        checks++; if (wa.size() !== 3) begin errors++; $display("FAIL pause_writes: got %0d want 3", wa.size()); end
        if (wa.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== 32'(i) || wd[i] !== 32'hB0 + 32'(i)) begin
                    errors++;
                    $display("FAIL pause_word%0d: got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, 32'hB0 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_overrun();
        start_run(32'd2, 5, 32'hC0);
        wait_done(60);
        repeat (4) tick();
        checks++; if (hs_cnt !== 2) begin errors++; $display("FAIL overrun_handshakes: got %0d want 2", hs_cnt); end
        checks++; if (wa.size() !== 2) begin errors++; $display("FAIL overrun_writes: got %0d want 2", wa.size()); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL overrun_ready: got %0b want 0", bus.in_ready); end
        if (wd.size() == 2) begin
            checks++;
            if (wd[0] !== 32'hC0 || wd[1] !== 32'hC1) begin errors++; $display("FAIL overrun_data: got %h %h want c0 c1", wd[0], wd[1]); end
        end
    endtask

    task automatic test_zero();
        start_run(32'd0, 0, 32'h0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b want 1", done); end
        repeat (3) tick();
        checks++; if (wa.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL zero_ready: got %0b want 0", ready_seen); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", count); end
    endtask

    task automatic test_abort();
        start_run(32'd8, 8, 32'hD0);
        for (int k = 0; k < 40 && wa.size() < 2; k++) tick();
        enable = 1'b0;
        tick();
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", count); end
        checks++; if (done !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_flags: got done=%0b we=%0b want 0 0", done, bus.mem_we); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", bus.in_ready); end
        start_run(32'd2, 2, 32'hE0);
        wait_done(60);
        checks++; if (wa.size() !== 2) begin errors++; $display("FAIL restart_writes: got %0d want 2", wa.size()); end
        if (wa.size() == 2) begin
            checks++;
            if (wa[0] !== 32'd0 || wa[1] !== 32'd1 || wd[0] !== 32'hE0 || wd[1] !== 32'hE1) begin
                errors++;
                $display("FAIL restart_words: got %0d:%h %0d:%h want 0:e0 1:e1", wa[0], wd[0], wa[1], wd[1]);
            end
        end
        checks++; if (count !== 32'd2) begin errors++; $display("FAIL restart_count: got %0d want 2", count); end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        start_run(32'd4, 4, 32'hF0);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.mem_we;
        end
        checks++; if (!seen) begin errors++; $display("FAIL async_hold_reached: got 0 want 1"); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_data !== 32'd0 || bus.mem_addr !== 32'd0 || count !== 32'd0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got we=%0b addr=%h data=%h count=%0d ready=%0b done=%0b want all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_data, count, bus.in_ready, done);
        end
        enable = 1'b0;
        bus.in_valid = 1'b0;
        n_offer = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        wa2.delete();
        filesize2     = 32'd3;
        bus2.in_valid = 1'b1;
        bus2.in_data  = 32'h77;
        enable2       = 1'b1;
        for (int k = 0; k < 60 && !done2; k++) tick();
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL wrap_done: got %0b want 1", done2); end
        checks++; if (wa2.size() !== 3) begin errors++; $display("FAIL wrap_writes: got %0d want 3", wa2.size()); end
        if (wa2.size() == 3) begin
            checks++;
            if (wa2[0] !== 4'd14 || wa2[1] !== 4'd15 || wa2[2] !== 4'd0) begin
                errors++;
                $display("FAIL wrap_addrs: got %0d %0d %0d want 14 15 0", wa2[0], wa2[1], wa2[2]);
            end
        end
        enable2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_overrun();
        test_zero();
        test_abort();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
